neuron_layer_scheduler: RTL and testbench

- Time-multiplexes one combinational LIF neuron core across N_NEURONS logical neurons, forming a small layer.
- Owns the per-neuron state: membrane registers, weight vectors, threshold and decay shift.
- On each accepted timestep, sequences the shared core through neuron indices 0..N_NEURONS-1, writes back membranes and collects spikes.
- Sits between the TT I/O wrapper (config/step interface) and the neuron datapath.

---
 rtl/neuron_layer_scheduler.sv | 116 +++++++++++
 tb/tb_neuron_layer_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_layer_scheduler.sv
// neuron_layer_scheduler: time-multiplexes one LIF core across N_NEURONS neurons, owning membranes, weights and config.
module neuron_layer_scheduler #(
    parameter int N_STAGE     = 3,
    parameter int N_NEURONS   = 8,
    parameter int N_MEMBRANE  = N_STAGE + 2,
    parameter int N_THRESHOLD = N_MEMBRANE - 1,
    localparam int N_IN       = 2 ** N_STAGE,
    localparam int IDX_W      = $clog2(N_NEURONS)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   step_valid_i,
    output logic                   step_ready_o,
    input  logic [N_IN-1:0]        step_inputs_i,
    input  logic                   cfg_we_i,
    input  logic [1:0]             cfg_sel_i,
    input  logic [IDX_W-1:0]       cfg_addr_i,
    input  logic [N_IN-1:0]        cfg_data_i,
    output logic [N_IN-1:0]        nc_inputs_o,
    output logic [N_IN-1:0]        nc_weights_o,
    output logic [2:0]             nc_shift_o,
    output logic [N_THRESHOLD-1:0] nc_threshold_o,
    output logic [N_MEMBRANE-1:0]  nc_last_membrane_o,
    input  logic [N_MEMBRANE-1:0]  nc_new_membrane_i,
    input  logic                   nc_is_spike_i,
    output logic [N_NEURONS-1:0]   spikes_o,
    output logic                   spikes_valid_o,
    output logic                   busy_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_NEURONS - 1);

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [N_MEMBRANE-1:0]    mem_q [N_NEURONS];
    logic [N_MEMBRANE-1:0]    mem_d [N_NEURONS];
    logic [N_IN-1:0]          w_q [N_NEURONS];
    logic [N_IN-1:0]          w_d [N_NEURONS];
    logic [N_THRESHOLD-1:0]   thr_q, thr_d;
    logic [2:0]               shift_q, shift_d;
    logic [N_IN-1:0]          in_q, in_d;
    logic [N_NEURONS-1:0]     work_q, work_d;
    logic [N_NEURONS-1:0]     spikes_q, spikes_d;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mem_d    = mem_q;
        w_d      = w_q;
        thr_d    = thr_q;
        shift_d  = shift_q;
        in_d     = in_q;
        work_d   = work_q;
        spikes_d = spikes_q;
        if (state_q == IDLE) begin
            if (cfg_we_i) begin
                if (cfg_sel_i == 2'd0) w_d[cfg_addr_i] = cfg_data_i;
                if (cfg_sel_i == 2'd1) thr_d = cfg_data_i[N_THRESHOLD-1:0];
                if (cfg_sel_i == 2'd2) shift_d = cfg_data_i[2:0];
                if (cfg_sel_i == 2'd3) for (int i = 0; i < N_NEURONS; i++) mem_d[i] = '0;
            end
            if (step_valid_i) begin
                state_d = RUN;
                idx_d   = '0;
                work_d  = '0;
                in_d    = step_inputs_i;
            end
        end else if (state_q == RUN) begin
            mem_d[idx_q]  = nc_new_membrane_i;
            work_d[idx_q] = nc_is_spike_i;
            idx_d         = idx_q + IDX_W'(1);
            // Publish on the last write so spikes_o is already fresh while spikes_valid_o pulses in DONE.
            if (idx_q == LAST) begin
                state_d  = DONE;
                spikes_d = work_d;
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            mem_q    <= '{default: '0};
            w_q      <= '{default: '0};
            thr_q    <= '1;
            shift_q  <= '0;
            in_q     <= '0;
            work_q   <= '0;
            spikes_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mem_q    <= mem_d;
            w_q      <= w_d;
            thr_q    <= thr_d;
            shift_q  <= shift_d;
            in_q     <= in_d;
            work_q   <= work_d;
            spikes_q <= spikes_d;
        end
    end

    assign nc_inputs_o        = in_q;
    assign nc_weights_o       = w_q[idx_q];
    assign nc_shift_o         = shift_q;
    assign nc_threshold_o     = thr_q;
    assign nc_last_membrane_o = mem_q[idx_q];
    assign spikes_o           = spikes_q;
    assign spikes_valid_o     = state_q == DONE;
    assign busy_o             = state_q != IDLE;
    assign step_ready_o       = state_q == IDLE;
endmodule

// File: tb/tb_neuron_layer_scheduler.sv
// tb_neuron_layer_scheduler: directed bench with a stub LIF core and a whole-step behavioural model.
module tb_neuron_layer_scheduler;
    localparam int N = 8;

    logic       clk = 0;
    logic       rst;
    logic       step_valid;
    logic       step_ready;
    logic [7:0] step_inputs;
    logic       cfg_we;
    logic [1:0] cfg_sel;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_data;
    logic [7:0] nc_in, nc_w;
    logic [2:0] nc_shift;
    logic [3:0] nc_thr;
    logic [4:0] nc_last, nc_new;
    logic       nc_spike;
    logic [7:0] spikes;
    logic       spikes_valid, busy;

    always #5 clk = ~clk;

    neuron_layer_scheduler dut (
        .clk_i(clk), .reset_i(rst),
        .step_valid_i(step_valid), .step_ready_o(step_ready), .step_inputs_i(step_inputs),
        .cfg_we_i(cfg_we), .cfg_sel_i(cfg_sel), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data),
        .nc_inputs_o(nc_in), .nc_weights_o(nc_w), .nc_shift_o(nc_shift), .nc_threshold_o(nc_thr),
        .nc_last_membrane_o(nc_last), .nc_new_membrane_i(nc_new), .nc_is_spike_i(nc_spike),
        .spikes_o(spikes), .spikes_valid_o(spikes_valid), .busy_o(busy)
    );

    // Stub core: accumulate the count of active weighted inputs, spike at threshold.
    assign nc_new   = nc_last + 5'($countones(nc_w & nc_in));
    assign nc_spike = $signed(nc_new) >= $signed({1'b0, nc_thr});

    int checks = 0;
    int passes = 0;
    bit en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Model: a whole step is evaluated at accept; m_phase tracks which neuron the core should be showing.
    int m_mem [N];
    int m_pre [N];
    int m_w [N];
    int m_thr, m_shift, m_in, m_work, m_spk;
    int m_phase = -1;

    always begin
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < N; i++) begin m_mem[i] = 0; m_w[i] = 0; end
            m_thr = 15; m_shift = 0; m_in = 0; m_spk = 0; m_work = 0; m_phase = -1;
        end else if (m_phase == -1) begin
            if (cfg_we) begin
                if (cfg_sel == 0) m_w[cfg_addr] = int'(cfg_data);
                if (cfg_sel == 1) m_thr = int'(cfg_data) % 16;
                if (cfg_sel == 2) m_shift = int'(cfg_data) % 8;
                if (cfg_sel == 3) for (int i = 0; i < N; i++) m_mem[i] = 0;
            end
            if (step_valid) begin
                m_in = int'(step_inputs);
                m_work = 0;
                for (int i = 0; i < N; i++) begin
                    m_pre[i] = m_mem[i];
                    m_mem[i] = m_pre[i] + $countones(m_in & m_w[i]);
                    if (m_mem[i] >= m_thr) m_work = m_work | (1 << i);
                end
                m_phase = 0;
            end
        end else if (m_phase < N) begin
            m_phase++;
            if (m_phase == N) m_spk = m_work;
        end else begin
            m_phase = -1;
        end
    end

    always begin
        @(negedge clk);
        if (en) begin
            chk("busy", busy, m_phase != -1);
            chk("step_ready", step_ready, m_phase == -1);
            chk("spikes_valid", spikes_valid, m_phase == N);
            chk("spikes", spikes, m_spk);
            chk("nc_threshold", nc_thr, m_thr);
            chk("nc_shift", nc_shift, m_shift);
            if (m_phase >= 0 && m_phase < N) begin
                chk("nc_weights", nc_w, m_w[m_phase]);
                chk("nc_last_membrane", nc_last, m_pre[m_phase]);
                chk("nc_inputs", nc_in, m_in);
            end else if (m_phase == -1) begin
                chk("idle_membrane0", nc_last, m_mem[0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cfg(input logic [1:0] s, input logic [2:0] a, input logic [7:0] d);
        cfg_we = 1; cfg_sel = s; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 0;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!step_ready && k < 50) begin tick(); k++; end
        if (k == 50) chk("ready_timeout", 0, 1);
    endtask

    task automatic wait_done(input int start, output int n);
        n = start;
        while (!spikes_valid && n < 30) begin tick(); n++; end
        if (!spikes_valid) begin n = -1; chk("done_timeout", 0, 1); end
    endtask

    task automatic do_step(input logic [7:0] in, input logic [7:0] exp_spk, input string nm);
        int n;
        wait_ready();
        step_valid = 1; step_inputs = in;
        tick();
        step_valid = 0;
        wait_done(1, n);
        chk({nm, "_latency"}, n, 9);
        chk({nm, "_spikes"}, spikes, exp_spk);
        tick();
    endtask

    initial begin
        int n, na, k;
        int t [3];
        rst = 1; step_valid = 0; step_inputs = 0; cfg_we = 0; cfg_sel = 0; cfg_addr = 0; cfg_data = 0;
        tick(); tick();
        rst = 0;
        en = 1;
        chk("rst_spikes", spikes, 0);
        chk("rst_spikes_valid", spikes_valid, 0);
        chk("rst_step_ready", step_ready, 1);
        chk("rst_threshold", nc_thr, 15);
        chk("rst_shift", nc_shift, 0);

        for (int i = 0; i < N; i++) cfg(0, 3'(i), 8'h01);
        cfg(1, 0, 8'd2);
        cfg(2, 0, 8'd5);
        do_step(8'h01, 8'h00, "basic1");
        chk("basic_mem0_after1", nc_last, 1);
        do_step(8'h01, 8'hFF, "basic2");

        cfg(3, 0, 0);
        for (int i = 0; i < N; i++) cfg(0, 3'(i), i == 3 ? 8'hFF : 8'h00);
        cfg(1, 0, 8'd4);
        do_step(8'h0F, 8'h08, "route");
        step_valid = 1; step_inputs = 8'h00;
        tick();
        step_valid = 0;
        chk("route_mem0", nc_last, 0);
        tick(); tick(); tick();
        chk("route_mem3", nc_last, 4);
        wait_done(4, n);
        chk("route_hold_spikes", spikes, 8'h08);
        tick();

        cfg(3, 0, 0);
        for (int i = 0; i < N; i++) cfg(0, 3'(i), 8'(1 << i));
        cfg(1, 0, 8'd2);
        step_valid = 1; step_inputs = 8'h03;
        na = 0; k = 0;
        while (na < 3 && k < 40) begin
            if (step_ready) begin t[na] = k; na++; end
            tick(); k++;
        end
        step_valid = 0;
        chk("b2b_accepts", na, 3);
        chk("b2b_period1", t[1] - t[0], 10);
        chk("b2b_period2", t[2] - t[1], 10);
        wait_done(1, n);
        chk("b2b_spikes", spikes, 8'h03);
        tick();

        cfg(3, 0, 0);
        for (int i = 0; i < N; i++) cfg(0, 3'(i), 8'h01);
        wait_ready();
        step_valid = 1; step_inputs = 8'h01;
        tick();
        step_valid = 0;
        tick(); tick();
        cfg(1, 0, 8'd1);
        wait_done(4, n);
        chk("busy_cfg_ignored", spikes, 8'h00);
        tick();

        cfg(3, 0, 0);
        cfg_we = 1; cfg_sel = 1; cfg_data = 8'd1; step_valid = 1; step_inputs = 8'h01;
        tick();
        cfg_we = 0; step_valid = 0;
        wait_done(1, n);
        chk("same_cycle_cfg", spikes, 8'hFF);
        tick();

        cfg(1, 0, 8'd2);
        cfg(3, 0, 0);
        do_step(8'h01, 8'h00, "clear_restep");

        for (int i = 0; i < N; i++) cfg(0, 3'(i), 8'hFF);
        step_valid = 1; step_inputs = 8'hFF;
        tick();
        step_valid = 0;
        tick(); tick(); tick();
        rst = 1;
        tick();
        rst = 0;
        chk("abort_ready", step_ready, 1);
        na = 0;
        for (int i = 0; i < 12; i++) begin
            if (spikes_valid) na++;
            tick();
        end
        chk("abort_no_pulse", na, 0);
        chk("abort_mem0", nc_last, 0);
        do_step(8'hFF, 8'h00, "after_abort");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
